// File: rtl/lc3_io_pkg.sv
// Shared LC-3 I/O constants and the keyboard bus access FSM encoding.
package lc3_io_pkg;

  localparam logic [15:0] KBSR_ADDR  = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR  = 16'hFE02;
  localparam logic [7:0]  KBD_VEC    = 8'h80;
  localparam int          WR_TIMEOUT = 4;
  localparam int          WR_CNT_W   = $clog2(WR_TIMEOUT);

  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_WIDTH = 5;

  typedef enum logic [2:0] {
    IDLE,
    RD_SR,
    RD_DR,
    WR_SR,
    WAIT_WR,
    DONE
  } acc_state_t;

  function automatic logic is_kbd_addr(input logic [15:0] addr);
    return (addr == KBSR_ADDR) || (addr == KBDR_ADDR);
  endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Small synchronous key-code FIFO; push is ignored when full, pop when empty.
module kbd_fifo
  import lc3_io_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/kbd_bus_if.sv
// LC-3 keyboard bus interface: KBSR/KBDR access FSM plus interrupt request logic.
// Optional build macro KBD_FIFO_EN buffers key codes in a 4-entry FIFO.
module kbd_bus_if
  import lc3_io_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] mar,
  input  logic [15:0] mdr_in,
  input  logic        mem_en,
  input  logic        r_w,
  input  logic [15:0] kbsr,
  input  logic [15:0] kbdr,
  input  logic        wr,
  output logic        ld_kbsr,
  output logic [15:0] kbsr_wdata,
  output logic        readed,
  output logic [15:0] rd_data,
  output logic        mem_rdy,
  output logic        intr_req,
  output logic [7:0]  intr_vec,
  input  logic        intr_ack
);

  acc_state_t          state;
  acc_state_t          state_next;
  logic [WR_CNT_W-1:0] to_cnt;
  logic [15:0]         sr_view;
  logic [15:0]         dr_view;
  logic                ready_bit;
  logic                int_cond;
  logic                int_cond_q;
  logic                int_rise;

`ifdef KBD_FIFO_EN
  logic       fifo_push;
  logic       fifo_pop;
  logic [4:0] fifo_dout;
  logic       fifo_empty;
  logic       fifo_full;

  // Keys are only taken while idle, so a push never collides with an ld_kbsr pulse.
  assign fifo_push = kbsr[15] && !fifo_full && (state == IDLE);
  assign fifo_pop  = (state == RD_DR) && !fifo_empty;

  kbd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(FIFO_WIDTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (kbdr[4:0]),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign ready_bit = !fifo_empty;
  assign sr_view   = {!fifo_empty, kbsr[14], 14'b0};
  assign dr_view   = fifo_empty ? 16'h0000 : {11'b0, fifo_dout};
  assign readed    = fifo_push;
`else
  assign ready_bit = kbsr[15];
  assign sr_view   = kbsr;
  assign dr_view   = kbdr;
  assign readed    = (state == RD_DR);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Writes to KBDR are dropped: the data register is read-only from the CPU side.
  always_comb begin
    state_next = state;
    ld_kbsr    = 1'b0;
    mem_rdy    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_en && is_kbd_addr(mar)) begin
          if (mar == KBSR_ADDR) state_next = r_w ? WR_SR : RD_SR;
          else if (!r_w)        state_next = RD_DR;
        end
      end
      RD_SR:   state_next = DONE;
      RD_DR:   state_next = DONE;
      WR_SR: begin
        ld_kbsr    = 1'b1;
        state_next = WAIT_WR;
      end
      WAIT_WR: begin
        if (wr || (to_cnt == WR_CNT_W'(WR_TIMEOUT - 1))) state_next = DONE;
      end
      DONE: begin
        mem_rdy    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data    <= 16'h0000;
      kbsr_wdata <= 16'h0000;
      to_cnt     <= '0;
    end else begin
      if (state == RD_SR) rd_data <= sr_view;
      if (state == RD_DR) rd_data <= dr_view;
      if ((state == IDLE) && (state_next == WR_SR)) kbsr_wdata <= mdr_in;
      if (state == WAIT_WR) to_cnt <= to_cnt + 1'b1;
      else                  to_cnt <= '0;
    end
  end

  assign int_cond = ready_bit && kbsr[14];
  assign int_rise = int_cond && !int_cond_q;
  assign intr_vec = intr_req ? KBD_VEC : 8'h00;

  // A fresh rising edge wins over a same-cycle acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_cond_q <= 1'b0;
      intr_req   <= 1'b0;
    end else begin
      int_cond_q <= int_cond;
      if (int_rise)                     intr_req <= 1'b1;
      else if (intr_ack || !kbsr[14])   intr_req <= 1'b0;
    end
  end

endmodule
